// File: rtl/crc_pkg.sv
// -----------------------------------------------------------------------------
// crc_pkg
// Shared definitions for the LUT-CRC table writer and the CRC datapath that
// consumes its tables.
//   - Table geometry (depth, address width, entry width).
//   - State encoding of the table-generator FSM.
//   - Commonly used generator polynomials (implicit x^32 term dropped).
//   - crc_div_step(): one MSB-first division step, shared by every user of
//     the shift-and-conditional-XOR primitive.
// -----------------------------------------------------------------------------
package crc_pkg;

    localparam int TABLE_DEPTH = 256;
    localparam int ENTRY_AW    = 8;
    localparam int CRC_W       = 32;

    // Generator polynomials, x^32 term implicit.
    localparam logic [CRC_W-1:0] POLY_EV27  = 32'h01717F5B;
    localparam logic [CRC_W-1:0] POLY_CRC32 = 32'h04C11DB7;

    // Table generator states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } gen_state_e;

    // One division step: shift left, fold the polynomial back in when the
    // bit leaving position 31 was set. The departing bit itself is dropped.
    function automatic logic [CRC_W-1:0] crc_div_step(
        input logic [CRC_W-1:0] crc,
        input logic [CRC_W-1:0] poly
    );
        logic [CRC_W-1:0] shifted;
        shifted = {crc[CRC_W-2:0], 1'b0};
        if (crc[CRC_W-1]) begin
            return shifted ^ poly;
        end else begin
            return shifted;
        end
    endfunction

endpackage : crc_pkg

// File: rtl/crc_bitstep.sv
// -----------------------------------------------------------------------------
// crc_bitstep
// Purely combinational single MSB-first CRC division step. Instances are
// chained to process several bits per clock.
// Ports:
//   crc_in   in  32  current remainder
//   poly     in  32  generator polynomial (x^32 implicit)
//   crc_out  out 32  remainder after one step
// -----------------------------------------------------------------------------
module crc_bitstep
    import crc_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [31:0] poly,
    output logic [31:0] crc_out
);

    assign crc_out = crc_div_step(crc_in, poly);

endmodule : crc_bitstep

// File: rtl/crc_table_gen.sv
// -----------------------------------------------------------------------------
// crc_table_gen
// Builds the 256-entry, 32-bit, MSB-first CRC lookup table for a polynomial
// chosen at run time and streams the entries into a table RAM through a
// write port with backpressure. Entry b is (b << 24) divided by 8 steps of
// shift-and-conditional-XOR with the polynomial.
//
// Parameters:
//   BITS_PER_CYCLE  division steps per clock; legal values 1, 2, 4, 8
//   CRC_W           entry width, fixed at 32
//
// Ports:
//   clk       in   1   clock
//   rst       in   1   synchronous active-high reset
//   start     in   1   build request, only looked at while idle
//   poly      in  32   polynomial, latched when a build is accepted
//   busy      out  1   high from the cycle after accepted start until DONE left
//   done      out  1   one-cycle pulse after the last write is accepted
//   wr_en     out  1   write request valid
//   wr_ready  in   1   RAM takes the write when wr_en && wr_ready
//   wr_addr   out  8   entry index
//   wr_data   out 32   entry value
//
// Per entry the FSM spends 8/BITS_PER_CYCLE cycles in SHIFT and at least one
// cycle in WRITE; address and data are held in registers so they stay stable
// for as long as the RAM stalls.
// -----------------------------------------------------------------------------
module crc_table_gen
    import crc_pkg::*;
#(
    parameter int BITS_PER_CYCLE = 1,
    parameter int CRC_W          = 32
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CRC_W-1:0] poly,
    output logic             busy,
    output logic             done,
    output logic             wr_en,
    input  logic             wr_ready,
    output logic [7:0]       wr_addr,
    output logic [CRC_W-1:0] wr_data
);

    // Number of SHIFT cycles per entry and the step-counter value on the last.
    localparam int         SHIFT_CYCLES = 8 / BITS_PER_CYCLE;
    localparam logic [2:0] LAST_SHIFT   = 3'(SHIFT_CYCLES - 1);
    localparam logic [ENTRY_AW-1:0] LAST_IDX = ENTRY_AW'(TABLE_DEPTH - 1);

    gen_state_e              r_state;
    logic [ENTRY_AW-1:0]     r_idx;
    logic [2:0]              r_step;
    logic [CRC_W-1:0]        r_poly_q;
    logic [CRC_W-1:0]        r_crc;
    logic                    r_busy;
    logic                    r_done;
    logic                    r_wr_en;
    logic [ENTRY_AW-1:0]     r_wr_addr;
    logic [CRC_W-1:0]        r_wr_data;

    // w_chain[0] is the stored remainder, w_chain[k] the remainder after k steps.
    logic [CRC_W-1:0]        w_chain [0:BITS_PER_CYCLE];
    logic                    w_accept;

    assign w_chain[0] = r_crc;

    genvar g;
    generate
        for (g = 0; g < BITS_PER_CYCLE; g++) begin : g_step
            crc_bitstep u_step (
                .crc_in  (w_chain[g]),
                .poly    (r_poly_q),
                .crc_out (w_chain[g+1])
            );
        end
    endgenerate

    assign w_accept = r_wr_en & wr_ready;

    // Table-build FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_idx     <= 8'h00;
            r_step    <= 3'd0;
            r_poly_q  <= 32'h0000_0000;
            r_crc     <= 32'h0000_0000;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= 8'h00;
            r_wr_data <= 32'h0000_0000;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done  <= 1'b0;
                    r_wr_en <= 1'b0;
                    if (start) begin
                        // Entry 0 starts from a zero remainder ({8'h00, 24'h0}).
                        r_poly_q <= poly;
                        r_idx    <= 8'h00;
                        r_crc    <= 32'h0000_0000;
                        r_step   <= 3'd0;
                        r_busy   <= 1'b1;
                        r_state  <= ST_SHIFT;
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end

                ST_SHIFT: begin
                    r_crc <= w_chain[BITS_PER_CYCLE];
                    if (r_step == LAST_SHIFT) begin
                        // Present the finished entry on the very next cycle.
                        r_step    <= 3'd0;
                        r_wr_en   <= 1'b1;
                        r_wr_addr <= r_idx;
                        r_wr_data <= w_chain[BITS_PER_CYCLE];
                        r_state   <= ST_WRITE;
                    end else begin
                        r_step  <= r_step + 3'd1;
                        r_state <= ST_SHIFT;
                    end
                end

                ST_WRITE: begin
                    if (w_accept) begin
                        r_wr_en <= 1'b0;
                        if (r_idx == LAST_IDX) begin
                            // Last entry taken: the index never wraps.
                            r_done  <= 1'b1;
                            r_state <= ST_DONE;
                        end else begin
                            r_idx   <= r_idx + 8'd1;
                            r_crc   <= {r_idx + 8'd1, 24'h00_0000};
                            r_state <= ST_SHIFT;
                        end
                    end else begin
                        // Stalled: address and data registers simply hold.
                        r_wr_en <= 1'b1;
                        r_state <= ST_WRITE;
                    end
                end

                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_wr_en <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign wr_en   = r_wr_en;
    assign wr_addr = r_wr_addr;
    assign wr_data = r_wr_data;

endmodule : crc_table_gen
